pipe_fetch: RTL and testbench

Parametrised instruction-fetch stage for the 5-stage MIPS pipeline. It owns the PC register, a loadable instruction memory of configurable depth, next-PC selection (sequential, jr, branch, j/jal), and the IF/ID pipeline register. It adds three things to the fetch path:
- stall and flush handling;
- a pending-redirect register, so a redirect that arrives during a stall is not lost;
- a selectable delay-slot mode.

Branch offsets are sign-extended.

---
 rtl/pipe_fetch.sv | 126 ++++++++++++
 tb/tb_pipe_fetch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_fetch.sv
// Instruction-fetch stage: PC register, loadable instruction memory, next-PC
// selection with a pending-redirect slot, and the IF/ID pipeline register.
module pipe_fetch #(
  parameter int          AW         = 5,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter bit          DELAY_SLOT = 1'b1,
  parameter logic [31:0] BUBBLE     = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          redir_en,
  input  logic [1:0]    redir_sel,
  input  logic [31:0]   redir_pc,
  input  logic [31:0]   pc_jr,
  input  logic [17:0]   imm18,
  input  logic [27:0]   index28,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [31:0]   imem_wdata,
  output logic [31:0]   pc,
  output logic          ifid_valid,
  output logic [31:0]   ifid_instr,
  output logic [31:0]   ifid_pc,
  output logic [31:0]   ifid_pc8,
  output logic          redir_pending,
  output logic          addr_err
);

  logic [31:0] r_imem [0:(1<<AW)-1];

  logic [31:0] r_pc;
  logic        r_pend_valid;
  logic [31:0] r_pend_pc;
  logic        r_addr_err;
  logic        r_ifid_valid;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_pc8;

  logic        w_redir_ok;
  logic [31:0] w_target;
  logic [31:0] w_fetch;
  logic [31:0] w_pc_next;
  logic        w_pend_valid_next;
  logic [31:0] w_pend_pc_next;
  logic        w_applied;
  logic        w_jr_misaligned;

  assign w_fetch = r_imem[r_pc[AW+1:2]];

  always_comb begin
    w_redir_ok      = redir_en && (redir_sel != 2'b00);
    w_jr_misaligned = w_redir_ok && (redir_sel == 2'b01) && (pc_jr[1:0] != 2'b00);
    case (redir_sel)
      2'b01:   w_target = {pc_jr[31:2], 2'b00};
      2'b10:   w_target = redir_pc + {{14{imm18[17]}}, imm18};
      2'b11:   w_target = {redir_pc[31:28], index28};
      default: w_target = r_pc;
    endcase
  end

  // A new redirect always beats a pending one; stall only captures.
  always_comb begin
    w_pc_next         = r_pc + 32'd4;
    w_pend_valid_next = r_pend_valid;
    w_pend_pc_next    = r_pend_pc;
    w_applied         = 1'b0;
    if (stall) begin
      w_pc_next = r_pc;
      if (w_redir_ok) begin
        w_pend_valid_next = 1'b1;
        w_pend_pc_next    = w_target;
      end
    end else if (w_redir_ok) begin
      w_pc_next         = w_target;
      w_pend_valid_next = 1'b0;
      w_applied         = 1'b1;
    end else if (r_pend_valid) begin
      w_pc_next         = r_pend_pc;
      w_pend_valid_next = 1'b0;
      w_applied         = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (imem_we) r_imem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= 32'h0;
      r_addr_err   <= 1'b0;
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= BUBBLE;
      r_ifid_pc    <= 32'h0;
      r_ifid_pc8   <= 32'h0;
    end else begin
      r_pc         <= w_pc_next;
      r_pend_valid <= w_pend_valid_next;
      r_pend_pc    <= w_pend_pc_next;
      if (w_jr_misaligned) r_addr_err <= 1'b1;
      if (flush || (!stall && !DELAY_SLOT && w_applied)) begin
        r_ifid_valid <= 1'b0;
        r_ifid_instr <= BUBBLE;
      end else if (!stall) begin
        r_ifid_valid <= 1'b1;
        r_ifid_instr <= w_fetch;
        r_ifid_pc    <= r_pc;
        r_ifid_pc8   <= r_pc + 32'd8;
      end
    end
  end

  assign pc            = r_pc;
  assign ifid_valid    = r_ifid_valid;
  assign ifid_instr    = r_ifid_instr;
  assign ifid_pc       = r_ifid_pc;
  assign ifid_pc8      = r_ifid_pc8;
  assign redir_pending = r_pend_valid;
  assign addr_err      = r_addr_err;

endmodule

// File: tb/tb_pipe_fetch.sv
// Bench for pipe_fetch: two instances (delay slot off/on) share stimulus and are
// checked each cycle against a queue of expected states from a reference model.
module tb_pipe_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 0, flush = 0, redir_en = 0, imem_we = 0;
  logic [1:0]  redir_sel = 0;
  logic [31:0] redir_pc = 0, pc_jr = 0, imem_wdata = 0;
  logic [17:0] imm18 = 0;
  logic [27:0] index28 = 0;
  logic [4:0]  imem_waddr = 0;

  logic        n_rst = 0, n_stall = 0, n_flush = 0, n_en = 0, n_we = 0;
  logic [1:0]  n_sel = 0;
  logic [31:0] n_rpc = 0, n_jr = 0, n_wd = 0;
  logic [17:0] n_imm = 0;
  logic [27:0] n_idx = 0;
  logic [4:0]  n_wa = 0;

  logic [31:0] pc0, ins0, ipc0, ipc80, pc1, ins1, ipc1, ipc81;
  logic        v0, pend0, ae0, v1, pend1, ae1;

  always #5 clk = ~clk;

  pipe_fetch #(.AW(5), .RESET_PC(32'h0), .DELAY_SLOT(1'b0), .BUBBLE(32'h0)) u_ds0 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .redir_en(redir_en),
    .redir_sel(redir_sel), .redir_pc(redir_pc), .pc_jr(pc_jr), .imm18(imm18),
    .index28(index28), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .pc(pc0), .ifid_valid(v0), .ifid_instr(ins0), .ifid_pc(ipc0), .ifid_pc8(ipc80),
    .redir_pending(pend0), .addr_err(ae0));

  pipe_fetch #(.AW(5), .RESET_PC(32'h0), .DELAY_SLOT(1'b1), .BUBBLE(32'h0)) u_ds1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .redir_en(redir_en),
    .redir_sel(redir_sel), .redir_pc(redir_pc), .pc_jr(pc_jr), .imm18(imm18),
    .index28(index28), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .pc(pc1), .ifid_valid(v1), .ifid_instr(ins1), .ifid_pc(ipc1), .ifid_pc8(ipc81),
    .redir_pending(pend1), .addr_err(ae1));

  typedef struct {
    logic [31:0] pc;
    logic        pv;
    logic [31:0] ppc;
    logic        ae;
    logic        v;
    logic [31:0] ins;
    logic [31:0] ipc;
    logic [31:0] ipc8;
  } st_t;

  typedef struct {
    st_t a;
    st_t b;
  } exp_t;

  st_t         m0, m1, rst_st;
  logic [31:0] mmem [32];
  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the fetch rules applied to one clock edge.
  function automatic st_t model(input st_t s, input bit ds);
    st_t         r = s;
    logic [31:0] word = mmem[s.pc[6:2]];
    logic [31:0] tgt = 0;
    int          off;
    bit          ok = redir_en && redir_sel != 0;
    bit          applied = 0;
    off = imm18[17] ? int'(imm18) - 262144 : int'(imm18);
    if (redir_sel == 2'b01) tgt = pc_jr & ~32'h3;
    else if (redir_sel == 2'b10) tgt = redir_pc + off;
    else tgt = (redir_pc & 32'hF000_0000) | {4'h0, index28};
    if (ok && redir_sel == 2'b01 && pc_jr[1:0] != 0) r.ae = 1;
    if (stall) begin
      if (ok) begin r.pv = 1; r.ppc = tgt; end
    end else if (ok) begin
      r.pc = tgt; r.pv = 0; applied = 1;
    end else if (s.pv) begin
      r.pc = s.ppc; r.pv = 0; applied = 1;
    end else r.pc = s.pc + 4;
    if (flush || (!stall && !ds && applied)) begin
      r.v = 0; r.ins = 32'h0;
    end else if (!stall) begin
      r.v = 1; r.ins = word; r.ipc = s.pc; r.ipc8 = s.pc + 8;
    end
    return r;
  endfunction

  task automatic step();
    @(negedge clk);
    rst_n = n_rst; stall = n_stall; flush = n_flush; redir_en = n_en; redir_sel = n_sel;
    redir_pc = n_rpc; pc_jr = n_jr; imm18 = n_imm; index28 = n_idx;
    imem_we = n_we; imem_waddr = n_wa; imem_wdata = n_wd;
    if (!rst_n) begin m0 = rst_st; m1 = rst_st; end
    else begin m0 = model(m0, 1'b0); m1 = model(m1, 1'b1); end
    if (imem_we) mmem[imem_waddr] = imem_wdata;
    q.push_back('{m0, m1});
    n_stall = 0; n_flush = 0; n_en = 0; n_sel = 0; n_rpc = 0; n_jr = 0;
    n_imm = 0; n_idx = 0; n_we = 0; n_wa = 0; n_wd = 0;
  endtask

  task automatic post();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("ds0 pc", pc0, e.a.pc);       cmp("ds1 pc", pc1, e.b.pc);
        cmp("ds0 valid", 32'(v0), 32'(e.a.v)); cmp("ds1 valid", 32'(v1), 32'(e.b.v));
        cmp("ds0 instr", ins0, e.a.ins);  cmp("ds1 instr", ins1, e.b.ins);
        cmp("ds0 ifid_pc", ipc0, e.a.ipc); cmp("ds1 ifid_pc", ipc1, e.b.ipc);
        cmp("ds0 pc8", ipc80, e.a.ipc8);  cmp("ds1 pc8", ipc81, e.b.ipc8);
        cmp("ds0 pending", 32'(pend0), 32'(e.a.pv)); cmp("ds1 pending", 32'(pend1), 32'(e.b.pv));
        cmp("ds0 addr_err", 32'(ae0), 32'(e.a.ae)); cmp("ds1 addr_err", 32'(ae1), 32'(e.b.ae));
      end
    end
  end

  initial begin : stim
    logic [31:0] held;
    rst_st = '{pc: 32'h0, pv: 0, ppc: 32'h0, ae: 0, v: 0, ins: 32'h0, ipc: 32'h0, ipc8: 32'h0};
    m0 = rst_st; m1 = rst_st;
    #1 rst_n = 1'b0;
    // Preload whole memory while in reset.
    for (int i = 0; i < 32; i++) begin
      n_rst = 0; n_we = 1; n_wa = 5'(i);
      n_wd = (i < 4) ? 32'h1111_1111 * (i + 1) : $urandom;
      step();
    end
    post();
    cmp("reset pc", pc0, 32'h0);
    cmp("reset valid", 32'(v1), 32'h0);

    // Free run, with a write to word 2 while PC=8.
    n_rst = 1;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin n_we = 1; n_wa = 5'd2; n_wd = 32'hDEAD_BEEF; end
      step(); post();
      cmp("run ifid_pc", ipc1, 32'(4 * k));
      cmp("run instr", ins1, 32'h1111_1111 * (k + 1));
      cmp("run pc8", ipc81, 32'(4 * k + 8));
    end
    step(); post();
    // Backward branch from 0x20 by -16.
    n_en = 1; n_sel = 2'b10; n_rpc = 32'h20; n_imm = 18'h3FFF0;
    step(); post();
    cmp("branch pc", pc0, 32'h10);
    cmp("squash valid", 32'(v0), 32'h0);
    cmp("squash instr", ins0, 32'h0);
    cmp("slot valid", 32'(v1), 32'h1);
    cmp("slot ifid_pc", ipc1, 32'h14);
    // Back to 8: new word visible.
    n_en = 1; n_sel = 2'b10; n_rpc = 32'h8; n_imm = 18'h0;
    step(); step(); post();
    cmp("new word", ins0, 32'hDEAD_BEEF);
    // Jump with wrap-around.
    n_en = 1; n_sel = 2'b11; n_rpc = 32'h9000_0000; n_idx = 28'h000_0084;
    step(); post();
    cmp("jump pc", pc1, 32'h9000_0084);
    step(); post();
    cmp("wrap instr", ins1, 32'h2222_2222);
    held = pc0;
    // Redirect during stall.
    n_stall = 1; step();
    n_stall = 1; n_en = 1; n_sel = 2'b01; n_jr = 32'h40; step(); post();
    cmp("stall pending", 32'(pend0), 32'h1);
    cmp("stall pc hold", pc0, held);
    n_stall = 1; step(); post();
    cmp("stall pending2", 32'(pend1), 32'h1);
    step(); post();
    cmp("release pc", pc0, 32'h40);
    cmp("release pending", 32'(pend0), 32'h0);
    // Newer redirect overrides older pending one.
    n_stall = 1; step();
    n_stall = 1; n_en = 1; n_sel = 2'b01; n_jr = 32'h40; step();
    n_stall = 1; n_en = 1; n_sel = 2'b10; n_rpc = 32'h100; n_imm = 18'h8; step();
    step(); post();
    cmp("override pc", pc1, 32'h108);
    // Misaligned jr.
    n_en = 1; n_sel = 2'b01; n_jr = 32'h43; step(); post();
    cmp("misaligned pc", pc0, 32'h40);
    cmp("addr_err set", 32'(ae0), 32'h1);
    step(); step(); post();
    cmp("addr_err sticky", 32'(ae1), 32'h1);
    // Flush during stall.
    n_stall = 1; n_flush = 1; step(); post();
    cmp("flush valid", 32'(v1), 32'h0);
    // Asynchronous reset with a redirect pending.
    n_stall = 1; n_en = 1; n_sel = 2'b11; n_idx = 28'h80; step();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    cmp("async pc", pc0, 32'h0);
    cmp("async pending", 32'(pend0), 32'h0);
    cmp("async addr_err", 32'(ae0), 32'h0);
    cmp("async ifid_valid", 32'(v1), 32'h0);
    n_rst = 0; step();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      n_rst   = 1;
      n_stall = ($urandom_range(0, 9) < 3);
      n_flush = ($urandom_range(0, 9) == 0);
      n_en    = ($urandom_range(0, 4) == 0);
      n_sel   = 2'($urandom);
      n_rpc   = $urandom;
      n_jr    = {24'h0, 8'($urandom)};
      n_imm   = 18'($urandom);
      n_idx   = {20'h0, 8'($urandom)};
      n_we    = ($urandom_range(0, 9) == 0);
      n_wa    = 5'($urandom);
      n_wd    = $urandom;
      step();
    end
    post(); post();
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain actual=%0d expected=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
